// File: rtl/falafel_pkg.sv
// Shared constants for the falafel allocator datapath.
// DATA_W is the response word width used by the output stage.
package falafel_pkg;
    parameter int DATA_W = 8;
endpackage

// File: rtl/falafel_rsp_serializer_if.sv
// Valid/ready response port of the falafel response serializer.
// master drives the beat; slave is the downstream consumer.
interface falafel_rsp_serializer_if #(
    parameter int DATA_W = 8,
    parameter int BEAT_W = 2
) ();
    logic              rsp_val_o;
    logic              rsp_rdy_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_last_o;
    logic [BEAT_W-1:0] rsp_beat_o;

    modport master (
        output rsp_val_o,
        output rsp_data_o,
        output rsp_last_o,
        output rsp_beat_o,
        input  rsp_rdy_i
    );

    modport slave (
        input  rsp_val_o,
        input  rsp_data_o,
        input  rsp_last_o,
        input  rsp_beat_o,
        output rsp_rdy_i
    );
endinterface

// File: rtl/falafel_rsp_serializer.sv
// Replays each response FIFO word 1..MAX_REP beats on a valid/ready port.
// Optional FALAFEL_RSP_SER_STATS_EN adds word/beat counters.
module falafel_rsp_serializer #(
    parameter int DATA_W  = falafel_pkg::DATA_W,
    parameter int MAX_REP = 4,
    localparam int REP_W  = $clog2(MAX_REP + 1),
    localparam int BEAT_W = (MAX_REP > 1) ? $clog2(MAX_REP) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [REP_W-1:0]     cfg_rep_i,
    falafel_rsp_serializer_if.master rsp,
    input  logic                 resp_fifo_empty_i,
    output logic                 resp_fifo_read_o,
    input  logic [DATA_W-1:0]    resp_fifo_dout_i
`ifdef FALAFEL_RSP_SER_STATS_EN
    ,
    output logic [31:0]          stat_words_o,
    output logic [31:0]          stat_beats_o
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [REP_W-1:0]    eff_rep;
    logic                pop;
    logic                last;
    logic                val;

    always_comb begin
        eff_rep = cfg_rep_i;
        if (cfg_rep_i == '0) begin
            eff_rep = REP_W'(1);
        end else if (cfg_rep_i > REP_W'(MAX_REP)) begin
            eff_rep = REP_W'(MAX_REP);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            rep_q   <= REP_W'(1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rep_q   <= rep_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rep_d   = rep_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        val     = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!resp_fifo_empty_i) begin
                    pop     = 1'b1;
                    buf_d   = resp_fifo_dout_i;
                    rep_d   = eff_rep;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                val  = 1'b1;
                last = (REP_W'(beat_q) == rep_q - REP_W'(1));
                if (rsp.rsp_rdy_i) begin
                    if (!last) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else if (!resp_fifo_empty_i) begin
                        // back-to-back reload keeps 1 beat/cycle at eff_rep=1
                        pop    = 1'b1;
                        buf_d  = resp_fifo_dout_i;
                        rep_d  = eff_rep;
                        beat_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // reset holds IDLE, so only the pop strobe needs explicit gating
    assign resp_fifo_read_o = pop & rst_ni;
    assign rsp.rsp_val_o    = val;
    assign rsp.rsp_last_o   = last;
    assign rsp.rsp_data_o   = (state_q == SEND) ? buf_q : '0;
    assign rsp.rsp_beat_o   = (state_q == SEND) ? beat_q : '0;

`ifdef FALAFEL_RSP_SER_STATS_EN
    logic [31:0] words_q;
    logic [31:0] beats_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            words_q <= '0;
            beats_q <= '0;
        end else begin
            if (resp_fifo_read_o) begin
                words_q <= words_q + 32'd1;
            end
            if (val && rsp.rsp_rdy_i) begin
                beats_q <= beats_q + 32'd1;
            end
        end
    end

    assign stat_words_o = words_q;
    assign stat_beats_o = beats_q;
`endif

endmodule

// File: tb/tb_falafel_rsp_serializer.sv
// Directed bench for falafel_rsp_serializer with a small FWFT FIFO model.
// Define FALAFEL_RSP_SER_STATS_EN to also check the statistics counters.
module tb_falafel_rsp_serializer;

    logic       clk;
    logic       rst_n;
    logic [2:0] cfg_rep;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] fifo_dout;
    logic [7:0] mem [32];
    logic [4:0] wr_ptr;
    logic [4:0] rd_ptr;
    int         total;
    int         bad;
`ifdef FALAFEL_RSP_SER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_beats;
`endif

    falafel_rsp_serializer_if #(.DATA_W(8), .BEAT_W(2)) rsp_if ();

    falafel_rsp_serializer #(
        .DATA_W  (8),
        .MAX_REP (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .cfg_rep_i         (cfg_rep),
        .rsp               (rsp_if),
        .resp_fifo_empty_i (fifo_empty),
        .resp_fifo_read_o  (fifo_read),
        .resp_fifo_dout_i  (fifo_dout)
`ifdef FALAFEL_RSP_SER_STATS_EN
        ,
        .stat_words_o      (stat_words),
        .stat_beats_o      (stat_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_read) rd_ptr <= rd_ptr + 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic tick(input logic r);
        @(negedge clk);
        rsp_if.rsp_rdy_i = r;
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] d,
                        input logic [1:0] b, input logic l,
                        input logic rd);
        chk({tag, "_val"},  32'(rsp_if.rsp_val_o),  32'd1);
        chk({tag, "_data"}, 32'(rsp_if.rsp_data_o), 32'(d));
        chk({tag, "_beat"}, 32'(rsp_if.rsp_beat_o), 32'(b));
        chk({tag, "_last"}, 32'(rsp_if.rsp_last_o), 32'(l));
        chk({tag, "_read"}, 32'(fifo_read),         32'(rd));
    endtask

    task automatic idle(input string tag);
        chk({tag, "_val"},  32'(rsp_if.rsp_val_o),  32'd0);
        chk({tag, "_data"}, 32'(rsp_if.rsp_data_o), 32'd0);
        chk({tag, "_beat"}, 32'(rsp_if.rsp_beat_o), 32'd0);
        chk({tag, "_last"}, 32'(rsp_if.rsp_last_o), 32'd0);
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!rsp_if.rsp_val_o && fifo_empty) begin
                done = 1'b1;
                break;
            end
            tick(1'b1);
        end
        chk({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        wr_ptr = '0;
        rd_ptr = '0;
        rst_n  = 1'b0;
        cfg_rep = 3'd2;
        rsp_if.rsp_rdy_i = 1'b0;

        // 1: reset state, then one word at two beats
        repeat (2) @(negedge clk);
        push(8'h0A);
        rsp_if.rsp_rdy_i = 1'b1;
        #1;
        idle("rst");
        chk("rst_read", 32'(fifo_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_pop", 32'(fifo_read), 32'd1);
        chk("t1_val", 32'(rsp_if.rsp_val_o), 32'd0);
        tick(1'b1); beat("t1_b0", 8'h0A, 2'd0, 1'b0, 1'b0);
        tick(1'b1); beat("t1_b1", 8'h0A, 2'd1, 1'b1, 1'b0);
        tick(1'b1); idle("t1_end");

        // 2: single-beat words stream with no bubbles
        cfg_rep = 3'd1;
        push(8'h01); push(8'h02); push(8'h03);
        #1;
        chk("t2_pop", 32'(fifo_read), 32'd1);
        tick(1'b1); beat("t2_w1", 8'h01, 2'd0, 1'b1, 1'b1);
        tick(1'b1); beat("t2_w2", 8'h02, 2'd0, 1'b1, 1'b1);
        tick(1'b1); beat("t2_w3", 8'h03, 2'd0, 1'b1, 1'b0);
        tick(1'b1); idle("t2_end");

        // 3: backpressure holds the beat
        cfg_rep = 3'd3;
        push(8'h33); push(8'h44);
        #1;
        chk("t3_pop", 32'(fifo_read), 32'd1);
        tick(1'b1); beat("t3_b0",  8'h33, 2'd0, 1'b0, 1'b0);
        tick(1'b0); beat("t3_b1a", 8'h33, 2'd1, 1'b0, 1'b0);
        tick(1'b0); beat("t3_b1b", 8'h33, 2'd1, 1'b0, 1'b0);
        tick(1'b1); beat("t3_b1c", 8'h33, 2'd1, 1'b0, 1'b0);
        tick(1'b1); beat("t3_b2",  8'h33, 2'd2, 1'b1, 1'b1);
        tick(1'b1); beat("t3_nx",  8'h44, 2'd0, 1'b0, 1'b0);
        drain("t3");

        // 4: cfg 0 -> 1 beat, cfg 7 -> clamp 4, mid-word cfg change
        cfg_rep = 3'd0;
        push(8'h50);
        #1;
        tick(1'b1); beat("t4_z", 8'h50, 2'd0, 1'b1, 1'b0);
        cfg_rep = 3'd7;
        tick(1'b1); idle("t4_gap");
        push(8'h60);
        #1;
        chk("t4_pop", 32'(fifo_read), 32'd1);
        tick(1'b1); beat("t4_b0", 8'h60, 2'd0, 1'b0, 1'b0);
        tick(1'b1); beat("t4_b1", 8'h60, 2'd1, 1'b0, 1'b0);
        cfg_rep = 3'd1;
        push(8'h61);
        tick(1'b1); beat("t4_b2", 8'h60, 2'd2, 1'b0, 1'b0);
        tick(1'b1); beat("t4_b3", 8'h60, 2'd3, 1'b1, 1'b1);
        tick(1'b1); beat("t4_n",  8'h61, 2'd0, 1'b1, 1'b0);
        tick(1'b1); idle("t4_end");

        // 5: async reset mid-word drops the word in flight
        cfg_rep = 3'd3;
        push(8'h70); push(8'h71);
        #1;
        tick(1'b1); beat("t5_b0", 8'h70, 2'd0, 1'b0, 1'b0);
        tick(1'b1); beat("t5_b1", 8'h70, 2'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        idle("t5_rst");
        chk("t5_rst_read", 32'(fifo_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_pop", 32'(fifo_read), 32'd1);
        idle("t5_rel");
        tick(1'b1); beat("t5_n0", 8'h71, 2'd0, 1'b0, 1'b0);
        tick(1'b1); beat("t5_n1", 8'h71, 2'd1, 1'b0, 1'b0);
        tick(1'b1); beat("t5_n2", 8'h71, 2'd2, 1'b1, 1'b0);
        tick(1'b1); idle("t5_end");
        chk("t5_empty", 32'(fifo_empty), 32'd1);

`ifdef FALAFEL_RSP_SER_STATS_EN
        // 6: counters over five two-beat words
        rst_n = 1'b0;
        #1;
        chk("t6_rst_w", stat_words, 32'd0);
        chk("t6_rst_b", stat_beats, 32'd0);
        cfg_rep = 3'd2;
        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        drain("t6");
        chk("t6_words", stat_words, 32'd5);
        chk("t6_beats", stat_beats, 32'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
